// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the multi-cycle slice-serial adder/subtractor.
package addsub_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int SLICE_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE_W-bit ripple slice: {cout, s} = a + b + cin.
module addsub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/mp_addsub.sv
// Slice-serial add/subtract: one SLICE_W slice per RUN cycle, LSB first, with a
// stored carry flag so wide additions can be chained word by word (ADC/SBC).
module mp_addsub
  import addsub_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int SLICE_W   = SLICE_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub,
  input  logic                 use_carry,
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] y,
  input  logic                 clear_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic                 neg,
  output logic                 carry_flag
);

  localparam int NSLICE = WORD_SIZE / SLICE_W;
  localparam int CNT_W  = $clog2(NSLICE + 1);

  generate
    if ((WORD_SIZE % SLICE_W) != 0 || SLICE_W < 1) begin : g_bad_size
      $fatal(1, "mp_addsub: WORD_SIZE must be a positive multiple of SLICE_W");
    end
  endgenerate

  state_t               state;
  logic [WORD_SIZE-1:0] x_sh;
  logic [WORD_SIZE-1:0] y_sh;
  logic [WORD_SIZE-1:0] sum_r;
  logic [WORD_SIZE-1:0] sum_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 c_r;
  logic                 x_msb;
  logic                 y_msb;
  logic                 cout_r;
  logic                 ovf_r;
  logic                 zero_r;
  logic                 neg_r;
  logic                 carry_flag_r;
  logic [SLICE_W-1:0]   s_sl;
  logic                 c_sl;
  logic                 last_slice;

  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (x_sh[SLICE_W-1:0]),
    .b    (y_sh[SLICE_W-1:0]),
    .cin  (c_r),
    .s    (s_sl),
    .cout (c_sl)
  );

  // Finished slices enter at the top of sum_r and shift down, so after NSLICE
  // cycles slice 0 has arrived at bit 0 and no variable part-select is needed.
  generate
    if (NSLICE == 1) begin : g_one_slice
      assign sum_nxt = s_sl;
    end else begin : g_multi_slice
      assign sum_nxt = {s_sl, sum_r[WORD_SIZE-1:SLICE_W]};
    end
  endgenerate

  assign last_slice = (cnt == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      x_sh         <= '0;
      y_sh         <= '0;
      sum_r        <= '0;
      cnt          <= '0;
      c_r          <= 1'b0;
      x_msb        <= 1'b0;
      y_msb        <= 1'b0;
      cout_r       <= 1'b0;
      ovf_r        <= 1'b0;
      zero_r       <= 1'b0;
      neg_r        <= 1'b0;
      carry_flag_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_sh  <= x;
            y_sh  <= sub ? ~y : y;
            x_msb <= x[WORD_SIZE-1];
            y_msb <= sub ? ~y[WORD_SIZE-1] : y[WORD_SIZE-1];
            c_r   <= use_carry ? carry_flag_r : sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          x_sh  <= x_sh >> SLICE_W;
          y_sh  <= y_sh >> SLICE_W;
          c_r   <= c_sl;
          sum_r <= sum_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last_slice) begin
            cout_r       <= c_sl;
            ovf_r        <= (x_msb == y_msb) && (sum_nxt[WORD_SIZE-1] != x_msb);
            zero_r       <= (sum_nxt == '0);
            neg_r        <= sum_nxt[WORD_SIZE-1];
            carry_flag_r <= c_sl;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Later assignment wins, so a clear beats a same-cycle carry update.
      if (clear_carry) carry_flag_r <= 1'b0;
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign sum        = sum_r;
  assign cout       = cout_r;
  assign ovf        = ovf_r;
  assign zero       = zero_r;
  assign neg        = neg_r;
  assign carry_flag = carry_flag_r;

endmodule
